adc_acq_sequencer: RTL and testbench

Run controller for the LTC2308 acquisition path. Host register writes arrive on the same cmd bus the ADC FIFO already latches. The sequencer shadows the acquisition configuration, optionally waits for the inject trigger, and emits ADC conversion-start pulses at a programmed interval. It counts completed accumulated packets up to a programmed total and records DMA back-pressure overruns. It replaces the free-running clock divider in front of the ADC controller and drives that controller's sample count.

---
 rtl/adc_seq_pkg.sv | 31 +++
 rtl/adc_acq_sequencer_timer.sv | 44 ++++
 rtl/adc_acq_sequencer.sv | 173 +++++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC acquisition sequencer.
// Register map, CTRL bit positions, FSM encoding and reset defaults.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_INTERVAL = 8'h01;
  localparam logic [7:0] ADDR_NSAMPLES = 8'h02;
  localparam logic [7:0] ADDR_NPACKETS = 8'h03;

  localparam int CTRL_ARM_BIT        = 0;
  localparam int CTRL_ABORT_BIT      = 1;
  localparam int CTRL_TRIG_MODE_BIT  = 2;
  localparam int CTRL_CONTINUOUS_BIT = 3;

  localparam int DEFAULT_INTERVAL = 160;
  localparam int DEFAULT_NSAMPLES = 4095;

  localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

  // A packet total of zero means a single packet
  function automatic logic [31:0] clamp_npackets(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_timer.sv
// Modulo-N interval counter. tick reports that the count about to be loaded is 0,
// so a caller registering its strobe from tick lands it in the zero-count cycle.
module adc_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] modulus,
  output logic         tick
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_next_s;

  // Next count: clear wins, otherwise advance and wrap at modulus-1
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {W{1'b0}};
    end else if (enable) begin
      if (count_r >= (modulus - W'(1))) begin
        count_next_s = {W{1'b0}};
      end else begin
        count_next_s = count_r + W'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  assign tick = (count_next_s == {W{1'b0}});

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Run controller for the LTC2308 acquisition path: shadows host config, waits for
// the inject trigger, paces conversion starts and counts packets and overruns.
module adc_acq_sequencer #(
  parameter int INTERVAL_W       = 16,
  parameter int DEFAULT_INTERVAL = adc_seq_pkg::DEFAULT_INTERVAL,
  parameter int DEFAULT_NSAMPLES = adc_seq_pkg::DEFAULT_NSAMPLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  input  logic        trig_in,
  input  logic        sink_ready,
  input  logic        accum_valid,
  output logic        adc_start,
  output logic [11:0] number_of_samples,
  output logic        busy,
  output logic        done,
  output logic [15:0] overrun_count,
  output logic [1:0]  state
);

  import adc_seq_pkg::*;

  localparam logic [INTERVAL_W-1:0] INTERVAL_MIN = INTERVAL_W'(2);
  localparam logic [INTERVAL_W-1:0] INTERVAL_RST = INTERVAL_W'(DEFAULT_INTERVAL);
  localparam logic [11:0]           NSAMPLES_RST = 12'(DEFAULT_NSAMPLES);

  seq_state_e            state_r;
  logic [INTERVAL_W-1:0] interval_shd_r, interval_act_r;
  logic [11:0]           nsamples_shd_r, nsamples_act_r;
  logic [31:0]           npackets_shd_r, npackets_act_r, pkt_cnt_r;
  logic [1:0]            mode_shd_r;   // {CONTINUOUS, TRIG_MODE}
  logic                  continuous_act_r, trig_prev_r;
  logic                  adc_start_r, busy_r, done_r;
  logic [15:0]           overrun_r;

  logic                  wr_ctrl_s, abort_s, arm_s, trig_fall_s, pkt_s, finish_s;
  logic                  run_next_s, tick_next_s, timer_clear_s, timer_en_s;
  logic [1:0]            mode_next_s;
  logic [INTERVAL_W-1:0] interval_wr_s;

  // Decode host writes and this cycle's run events
  always_comb begin
    wr_ctrl_s   = cmd_valid && (cmd_addr == ADDR_CTRL);
    abort_s     = wr_ctrl_s && cmd_data[CTRL_ABORT_BIT];
    arm_s       = wr_ctrl_s && cmd_data[CTRL_ARM_BIT] && !abort_s && (state_r == IDLE);
    trig_fall_s = trig_prev_r && !trig_in;
    pkt_s       = accum_valid && (state_r == RUN) && !abort_s;
    finish_s    = pkt_s && !continuous_act_r && (pkt_cnt_r == (npackets_act_r - 32'd1));
    timer_clear_s = (state_r != RUN);
    timer_en_s    = (state_r == RUN);
    if (wr_ctrl_s) begin
      mode_next_s = {cmd_data[CTRL_CONTINUOUS_BIT], cmd_data[CTRL_TRIG_MODE_BIT]};
    end else begin
      mode_next_s = mode_shd_r;
    end
    if (cmd_data[INTERVAL_W-1:0] < INTERVAL_MIN) begin
      interval_wr_s = INTERVAL_MIN;
    end else begin
      interval_wr_s = cmd_data[INTERVAL_W-1:0];
    end
    // The start strobe is registered, so it is decided from where the FSM is heading
    case (state_r)
      IDLE:      run_next_s = arm_s && !mode_next_s[0];
      WAIT_TRIG: run_next_s = !abort_s && trig_fall_s;
      RUN:       run_next_s = !abort_s && !finish_s;
      default:   run_next_s = 1'b0;
    endcase
  end

  adc_interval_timer #(
    .W(INTERVAL_W)
  ) u_interval_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .modulus (interval_act_r),
    .tick    (tick_next_s)
  );

  // Host-visible shadow configuration and trigger history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_shd_r <= INTERVAL_RST;
      nsamples_shd_r <= NSAMPLES_RST;
      npackets_shd_r <= 32'd1;
      mode_shd_r     <= 2'b00;
      trig_prev_r    <= 1'b0;
    end else begin
      trig_prev_r <= trig_in;
      mode_shd_r  <= mode_next_s;
      if (cmd_valid) begin
        case (cmd_addr)
          ADDR_INTERVAL: interval_shd_r <= interval_wr_s;
          ADDR_NSAMPLES: nsamples_shd_r <= cmd_data[11:0];
          ADDR_NPACKETS: npackets_shd_r <= clamp_npackets(cmd_data);
          default:       interval_shd_r <= interval_shd_r;
        endcase
      end
    end
  end

  // Sequencer FSM, active config, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      interval_act_r   <= INTERVAL_RST;
      nsamples_act_r   <= NSAMPLES_RST;
      npackets_act_r   <= 32'd1;
      continuous_act_r <= 1'b0;
      pkt_cnt_r        <= 32'd0;
      overrun_r        <= 16'd0;
      adc_start_r      <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      adc_start_r <= run_next_s && tick_next_s;
      done_r      <= finish_s;
      if (abort_s) begin
        state_r   <= IDLE;
        busy_r    <= 1'b0;
        pkt_cnt_r <= 32'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (arm_s) begin
              state_r          <= mode_next_s[0] ? WAIT_TRIG : RUN;
              busy_r           <= 1'b1;
              pkt_cnt_r        <= 32'd0;
              overrun_r        <= 16'd0;
              interval_act_r   <= interval_shd_r;
              nsamples_act_r   <= nsamples_shd_r;
              npackets_act_r   <= npackets_shd_r;
              continuous_act_r <= mode_next_s[1];
            end
          end
          WAIT_TRIG: begin
            if (trig_fall_s) begin
              state_r <= RUN;
            end
          end
          RUN: begin
            if (pkt_s) begin
              pkt_cnt_r <= pkt_cnt_r + 32'd1;
              if (!sink_ready && (overrun_r != OVERRUN_MAX)) begin
                overrun_r <= overrun_r + 16'd1;
              end
            end
            if (finish_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_start         = adc_start_r;
  assign number_of_samples = nsamples_act_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign overrun_count     = overrun_r;
  assign state             = state_r;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: directed scenarios plus randomized
// runs, all compared against a cycle-count model of the sequencer's rules.
module tb_adc_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid, trig_in, sink_ready, accum_valid;
  logic        adc_start, busy, done;
  logic [11:0] number_of_samples;
  logic [15:0] overrun_count;
  logic [1:0]  state;

  adc_acq_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .trig_in(trig_in), .sink_ready(sink_ready),
    .accum_valid(accum_valid), .adc_start(adc_start),
    .number_of_samples(number_of_samples), .busy(busy), .done(done),
    .overrun_count(overrun_count), .state(state)
  );

  always #10 clk = ~clk;

  logic [32:0] obs;
  assign obs = {adc_start, busy, done, state, overrun_count, number_of_samples};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: run phase (0 idle, 1 waiting, 2 running), cycles since run start
  int          sh_int, act_int, m_st, m_k, m_ovr;
  logic [11:0] sh_ns, act_ns;
  logic [31:0] sh_np, act_np, m_pkts;
  bit          act_cont, m_prev_trig, m_done, trig_lvl;

  task automatic model_reset();
    sh_int = 160; act_int = 160; sh_ns = 12'hFFF; act_ns = 12'hFFF;
    sh_np = 32'd1; act_np = 32'd1; act_cont = 1'b0;
    m_st = 0; m_k = 0; m_ovr = 0; m_pkts = 32'd0; m_prev_trig = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic [32:0] exp_obs();
    logic e_adc;
    e_adc = (m_st == 2) && ((m_k % act_int) == 0);
    return {e_adc, (m_st != 0), m_done, 2'(m_st), 16'(m_ovr), act_ns};
  endfunction

  // Apply one cycle of inputs to both the model and the DUT
  task automatic step(input logic [7:0] a, input logic [31:0] d, input bit v,
                      input bit acc, input bit snk);
    bit wr_ctrl, abort, arm, fall;
    int nst;
    wr_ctrl = v && (a == 8'h00);
    abort   = wr_ctrl && d[1];
    arm     = wr_ctrl && d[0] && !abort && (m_st == 0);
    fall    = m_prev_trig && !trig_lvl;
    nst     = m_st;
    m_done  = 1'b0;
    if (abort) begin
      nst = 0; m_pkts = 32'd0;
    end else if (arm) begin
      act_int = sh_int; act_ns = sh_ns; act_np = sh_np; act_cont = d[3];
      m_pkts = 32'd0; m_ovr = 0; nst = d[2] ? 1 : 2;
    end else if (m_st == 1 && fall) begin
      nst = 2;
    end else if (m_st == 2 && acc) begin
      m_pkts = m_pkts + 32'd1;
      if (!snk && m_ovr < 65535) m_ovr++;
      if (!act_cont && m_pkts == act_np) begin
        nst = 0; m_done = 1'b1;
      end
    end
    if (v && a == 8'h01) sh_int = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
    if (v && a == 8'h02) sh_ns = d[11:0];
    if (v && a == 8'h03) sh_np = (d == 32'd0) ? 32'd1 : d;
    m_k = (nst == 2 && m_st == 2) ? m_k + 1 : 0;
    m_st = nst;
    m_prev_trig = trig_lvl;
    cmd_addr = a; cmd_data = d; cmd_valid = v; accum_valid = acc; sink_ready = snk;
    trig_in = trig_lvl;
    @(posedge clk); #1;
    cmd_valid = 1'b0; accum_valid = 1'b0; sink_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs !== exp_obs()) $display("FAIL reset_outputs: got %h expected %h", obs, exp_obs());
    else n_pass++;
    n_checks++;
    if (number_of_samples !== 12'd4095 || overrun_count !== 16'd0)
      $display("FAIL reset_defaults: got ns=%0d ovr=%0d expected ns=4095 ovr=0", number_of_samples, overrun_count);
    else n_pass++;
  endtask

  task automatic test_basic_run();
    int n_starts, n_done;
    bit acc;
    step(8'h01, 32'd10, 1'b1, 1'b0, 1'b1);
    step(8'h03, 32'd3, 1'b1, 1'b0, 1'b1);
    step(8'h02, 32'h123, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
    n_starts = int'(adc_start); n_done = 0;
    n_checks++;
    if (obs !== exp_obs()) $display("FAIL basic_arm: got %h expected %h", obs, exp_obs());
    else n_pass++;
    for (int i = 0; i < 45; i++) begin
      acc = (i == 7) || (i == 18) || (i == 29);
      if (i == 12) step(8'h00, 32'h1, 1'b1, acc, 1'b1);
      else         step(8'h00, 32'h0, 1'b0, acc, 1'b1);
      n_starts += int'(adc_start);
      n_done   += int'(done);
      n_checks++;
      if (obs !== exp_obs()) $display("FAIL basic[%0d]: got %h expected %h", i, obs, exp_obs());
      else n_pass++;
    end
    n_checks++;
    if (n_starts != 3 || n_done != 1 || busy !== 1'b0)
      $display("FAIL basic_totals: got starts=%0d dones=%0d busy=%b expected 3 1 0", n_starts, n_done, busy);
    else n_pass++;
  endtask

  task automatic test_trigger();
    trig_lvl = 1'b1;
    step(8'h01, 32'd6, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs !== exp_obs() || adc_start !== 1'b0 || state !== 2'd1)
        $display("FAIL trig_wait[%0d]: got %h expected %h", i, obs, exp_obs());
      else n_pass++;
    end
    trig_lvl = 1'b0;
    step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (obs !== exp_obs() || (i == 0 && adc_start !== 1'b1))
        $display("FAIL trig_run[%0d]: got %h expected %h", i, obs, exp_obs());
      else n_pass++;
      step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    step(8'h00, 32'h2, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs !== exp_obs() || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL trig_abort: got %h expected %h", obs, exp_obs());
    else n_pass++;
  endtask

  task automatic test_interval_clamp();
    int n_starts, n_done;
    for (int v = 0; v < 2; v++) begin
      step(8'h01, 32'(v), 1'b1, 1'b0, 1'b1);
      step(8'h03, 32'd100, 1'b1, 1'b0, 1'b1);
      step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
      n_starts = int'(adc_start);
      for (int i = 0; i < 8; i++) begin
        step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
        n_starts += int'(adc_start);
      end
      n_checks++;
      if (obs !== exp_obs() || n_starts != 5)
        $display("FAIL clamp_interval_%0d: got starts=%0d expected 5", v, n_starts);
      else n_pass++;
      step(8'h00, 32'h2, 1'b1, 1'b0, 1'b1);
    end
    step(8'h03, 32'd0, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 32'h0, 1'b0, (i == 3), 1'b1);
      n_done += int'(done);
      n_checks++;
      if (obs !== exp_obs()) $display("FAIL npackets_zero[%0d]: got %h expected %h", i, obs, exp_obs());
      else n_pass++;
    end
    n_checks++;
    if (n_done != 1) $display("FAIL npackets_zero_done: got %0d expected 1", n_done);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int pkt;
    step(8'h01, 32'd4, 1'b1, 1'b0, 1'b1);
    step(8'h03, 32'd5, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
    pkt = 0;
    for (int i = 0; i < 18; i++) begin
      if (i % 3 == 2) begin
        step(8'h00, 32'h0, 1'b0, 1'b1, !(pkt == 1 || pkt == 3));
        pkt++;
      end else begin
        step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
      end
      n_checks++;
      if (obs !== exp_obs()) $display("FAIL overrun[%0d]: got %h expected %h", i, obs, exp_obs());
      else n_pass++;
    end
    n_checks++;
    if (overrun_count !== 16'd2 || busy !== 1'b0)
      $display("FAIL overrun_total: got %0d busy=%b expected 2 busy=0", overrun_count, busy);
    else n_pass++;
  endtask

  task automatic test_overrun_saturate();
    step(8'h01, 32'd7, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h9, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      step(8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
      if (i % 10000 == 9999) begin
        n_checks++;
        if (obs !== exp_obs()) $display("FAIL saturate[%0d]: got %h expected %h", i, obs, exp_obs());
        else n_pass++;
      end
    end
    n_checks++;
    if (overrun_count !== 16'hFFFF || busy !== 1'b1)
      $display("FAIL saturate_value: got %h busy=%b expected ffff busy=1", overrun_count, busy);
    else n_pass++;
    step(8'h00, 32'h2, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp_obs() || overrun_count !== 16'hFFFF || busy !== 1'b0)
      $display("FAIL saturate_abort: got %h expected %h", obs, exp_obs());
    else n_pass++;
  endtask

  task automatic test_abort_priority();
    step(8'h01, 32'd3, 1'b1, 1'b0, 1'b1);
    step(8'h03, 32'd2, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 32'h2, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== exp_obs() || done !== 1'b0 || overrun_count !== 16'd0 || state !== 2'd0)
      $display("FAIL abort_with_packet: got %h expected %h", obs, exp_obs());
    else n_pass++;
    step(8'h00, 32'h3, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs !== exp_obs() || busy !== 1'b0) $display("FAIL arm_abort_write: got %h expected %h", obs, exp_obs());
    else n_pass++;
    step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== exp_obs() || busy !== 1'b0) $display("FAIL arm_abort_after: got %h expected %h", obs, exp_obs());
    else n_pass++;
  endtask

  task automatic test_nsamples_shadow();
    step(8'h02, 32'h0AB, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h9, 1'b1, 1'b0, 1'b1);
    step(8'h02, 32'h155, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (number_of_samples !== 12'h0AB || obs !== exp_obs())
      $display("FAIL nsamples_busy: got %h expected 0ab", number_of_samples);
    else n_pass++;
    step(8'h00, 32'h2, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (number_of_samples !== 12'h0AB) $display("FAIL nsamples_abort: got %h expected 0ab", number_of_samples);
    else n_pass++;
    step(8'h00, 32'h1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (number_of_samples !== 12'h155 || obs !== exp_obs())
      $display("FAIL nsamples_rearm: got %h expected 155", number_of_samples);
    else n_pass++;
    step(8'h00, 32'h2, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random_runs();
    logic [7:0]  a;
    logic [31:0] d;
    for (int r = 0; r < 8; r++) begin
      step(8'h01, 32'($urandom_range(0, 9)), 1'b1, 1'b0, 1'b1);
      step(8'h03, 32'($urandom_range(0, 4)), 1'b1, 1'b0, 1'b1);
      step(8'h02, 32'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b1);
      step(8'h00, {28'd0, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, 2'b01}, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 5) == 0) trig_lvl = !trig_lvl;
        if ($urandom_range(0, 19) == 0) begin
          a = 8'($urandom_range(0, 4));
          d = (a == 8'h00) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 12));
          step(a, d, 1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end else begin
          step(8'h00, 32'h0, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end
        n_checks++;
        if (obs !== exp_obs()) $display("FAIL random[%0d.%0d]: got %h expected %h", r, i, obs, exp_obs());
        else n_pass++;
      end
      step(8'h00, 32'h2, 1'b1, 1'b0, 1'b1);
    end
    trig_lvl = 1'b0;
    step(8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    step(8'h01, 32'd5, 1'b1, 1'b0, 1'b1);
    step(8'h00, 32'h9, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    #4 reset_n = 1'b0;
    #1 model_reset();
    n_checks++;
    if (obs !== exp_obs() || busy !== 1'b0 || state !== 2'd0 || overrun_count !== 16'd0)
      $display("FAIL reset_mid_run: got %h expected %h", obs, exp_obs());
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== exp_obs() || done !== 1'b0) $display("FAIL reset_hold: got %h expected %h", obs, exp_obs());
    else n_pass++;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; cmd_addr = 8'h00; cmd_data = 32'h0; cmd_valid = 1'b0;
    trig_in = 1'b0; sink_ready = 1'b1; accum_valid = 1'b0; trig_lvl = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_basic_run();
    test_trigger();
    test_interval_clamp();
    test_overrun();
    test_abort_priority();
    test_nsamples_shadow();
    test_random_runs();
    test_overrun_saturate();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
